host_bus_arbiter: RTL and testbench

Round-robin arbiter that shares the single host command port of `simple_axi_master` between `C_NUM_HOSTS` requesters. It latches one command at a time, issues it to the master, and waits for a done, error or invalid status. It then routes the result and read data back to the owning requester and clears the master for the next grant. It sits directly in front of the AXI master, between the master and the host-side logic.

---
 rtl/host_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_host_bus_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_bus_arbiter.sv
// Round-robin share of the single simple_axi_master command port; one command in flight, sticky status per requester.
// Grant-to-issue 1 cycle, status-to-done 1 cycle; no grant while the master still shows wait or any status.
module host_bus_arbiter #(
  parameter int C_NUM_HOSTS  = 4,
  parameter int C_DATA_WIDTH = 64
) (
  input  logic                                i_clk,
  input  logic                                i_rstn,
  input  logic [2*C_NUM_HOSTS-1:0]            i_req_rw,
  input  logic [3*C_NUM_HOSTS-1:0]            i_req_size,
  input  logic [32*C_NUM_HOSTS-1:0]           i_req_addr,
  input  logic [C_DATA_WIDTH*C_NUM_HOSTS-1:0] i_req_wdata,
  input  logic [C_NUM_HOSTS-1:0]              i_req_clear,
  output logic [C_DATA_WIDTH*C_NUM_HOSTS-1:0] o_req_rdata,
  output logic [C_NUM_HOSTS-1:0]              o_req_wait,
  output logic [C_NUM_HOSTS-1:0]              o_req_done,
  output logic [C_NUM_HOSTS-1:0]              o_req_error,
  output logic [C_NUM_HOSTS-1:0]              o_req_invalid,
  output logic [1:0]                          o_m_rw,
  output logic [2:0]                          o_m_size,
  output logic [31:0]                         o_m_addr,
  output logic [C_DATA_WIDTH-1:0]             o_m_wdata,
  output logic                                o_m_clear,
  input  logic                                i_m_wait,
  input  logic                                i_m_done,
  input  logic                                i_m_error,
  input  logic                                i_m_invalid,
  input  logic [C_DATA_WIDTH-1:0]             i_m_rdata,
  output logic [C_NUM_HOSTS-1:0]              o_grant,
  output logic [1:0]                          o_state
);

  localparam int N  = C_NUM_HOSTS;
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [IW-1:0]           owner, last_grant, win_idx, cand;
  logic                    win_vld, m_status, do_grant, cmd_active;
  logic [N-1:0]            eligible, done_q, error_q, invalid_q;
  logic [1:0]              cmd_rw;
  logic [2:0]              cmd_size;
  logic [31:0]             cmd_addr;
  logic [C_DATA_WIDTH-1:0] cmd_wdata;
  logic [C_DATA_WIDTH*N-1:0] rdata_q;

  assign m_status = i_m_done | i_m_error | i_m_invalid;

  // A requester with unacknowledged status is not eligible, so set and clear never collide.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N; i++) begin
      eligible[i] = (i_req_rw[2*i +: 2] != 2'b00) && !(done_q[i] | error_q[i] | invalid_q[i]);
    end
  end

  // Scan from farthest to nearest so the nearest index after last_grant wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(last_grant) + k) % N);
      if (eligible[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_m_rw    = 2'b00;
    o_m_clear = 1'b0;
    o_grant   = '0;
    case (state)
      S_IDLE: begin
        if (win_vld && !i_m_wait && !m_status) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        o_m_rw         = cmd_rw;
        o_grant[owner] = 1'b1;
        state_nxt      = S_BUSY;
      end
      S_BUSY: begin
        o_grant[owner] = 1'b1;
        if (m_status) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        o_m_clear = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign do_grant   = (state == S_IDLE) && (state_nxt == S_ISSUE);
  assign cmd_active = (state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      owner      <= '0;
      last_grant <= IW'(N - 1);
      cmd_rw     <= '0;
      cmd_size   <= '0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      done_q     <= '0;
      error_q    <= '0;
      invalid_q  <= '0;
      rdata_q    <= '0;
    end else begin
      if (do_grant) begin
        owner      <= win_idx;
        last_grant <= win_idx;
        cmd_rw     <= i_req_rw[2*win_idx +: 2];
        cmd_size   <= i_req_size[3*win_idx +: 3];
        cmd_addr   <= i_req_addr[32*win_idx +: 32];
        cmd_wdata  <= i_req_wdata[C_DATA_WIDTH*win_idx +: C_DATA_WIDTH];
      end
      done_q    <= done_q & ~i_req_clear;
      error_q   <= error_q & ~i_req_clear;
      invalid_q <= invalid_q & ~i_req_clear;
      // Read data is captured on every completion, writes included.
      if (state == S_BUSY && m_status) begin
        done_q[owner]    <= i_m_done;
        error_q[owner]   <= i_m_error;
        invalid_q[owner] <= i_m_invalid;
        rdata_q[C_DATA_WIDTH*owner +: C_DATA_WIDTH] <= i_m_rdata;
      end
    end
  end

  assign o_m_size      = cmd_active ? cmd_size  : '0;
  assign o_m_addr      = cmd_active ? cmd_addr  : '0;
  assign o_m_wdata     = cmd_active ? cmd_wdata : '0;
  assign o_req_wait    = o_grant;
  assign o_req_done    = done_q;
  assign o_req_error   = error_q;
  assign o_req_invalid = invalid_q;
  assign o_req_rdata   = rdata_q;
  assign o_state       = state;

endmodule

// File: tb/tb_host_bus_arbiter.sv
// Scoreboard bench for host_bus_arbiter: stimulus queues expected issues/completions,
// a behavioural master answers commands, and a monitor checks every issue and clear pulse.
module tb_host_bus_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;

  logic            i_clk = 1'b0;
  logic            i_rstn = 1'b0;
  logic [2*N-1:0]  i_req_rw;
  logic [3*N-1:0]  i_req_size;
  logic [32*N-1:0] i_req_addr;
  logic [DW*N-1:0] i_req_wdata;
  logic [N-1:0]    i_req_clear;
  logic [DW*N-1:0] o_req_rdata;
  logic [N-1:0]    o_req_wait, o_req_done, o_req_error, o_req_invalid;
  logic [1:0]      o_m_rw;
  logic [2:0]      o_m_size;
  logic [31:0]     o_m_addr;
  logic [DW-1:0]   o_m_wdata;
  logic            o_m_clear;
  logic            i_m_wait, i_m_done, i_m_error, i_m_invalid;
  logic [DW-1:0]   i_m_rdata;
  logic [N-1:0]    o_grant;
  logic [1:0]      o_state;

  host_bus_arbiter #(.C_NUM_HOSTS(N), .C_DATA_WIDTH(DW)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_req_rw(i_req_rw), .i_req_size(i_req_size), .i_req_addr(i_req_addr),
    .i_req_wdata(i_req_wdata), .i_req_clear(i_req_clear),
    .o_req_rdata(o_req_rdata), .o_req_wait(o_req_wait), .o_req_done(o_req_done),
    .o_req_error(o_req_error), .o_req_invalid(o_req_invalid),
    .o_m_rw(o_m_rw), .o_m_size(o_m_size), .o_m_addr(o_m_addr), .o_m_wdata(o_m_wdata),
    .o_m_clear(o_m_clear), .i_m_wait(i_m_wait), .i_m_done(i_m_done),
    .i_m_error(i_m_error), .i_m_invalid(i_m_invalid), .i_m_rdata(i_m_rdata),
    .o_grant(o_grant), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { int h; logic [1:0] rw; logic [2:0] size; logic [31:0] addr; logic [63:0] wdata; } iss_t;
  typedef struct { int lat; int hold; logic d; logic e; logic v; logic [63:0] rdata; } rsp_t;
  typedef struct { int h; logic d; logic e; logic v; logic [63:0] rdata; } cmp_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];
  cmp_t cmp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_cmd(input int h, input logic [1:0] rw, input logic [2:0] size,
                            input logic [31:0] addr, input logic [63:0] wdata, input int lat,
                            input int hold, input logic d, input logic e, input logic v,
                            input logic [63:0] rdata);
    iss_t it; rsp_t rs; cmp_t cp;
    it.h = h; it.rw = rw; it.size = size; it.addr = addr; it.wdata = wdata;
    rs.lat = lat; rs.hold = hold; rs.d = d; rs.e = e; rs.v = v; rs.rdata = rdata;
    cp.h = h; cp.d = d; cp.e = e; cp.v = v; cp.rdata = rdata;
    iss_q.push_back(it);
    rsp_q.push_back(rs);
    cmp_q.push_back(cp);
  endtask

  task automatic drive(input int h, input logic [1:0] rw, input logic [2:0] size,
                       input logic [31:0] addr, input logic [63:0] wdata);
    i_req_rw[2*h +: 2]     = rw;
    i_req_size[3*h +: 3]   = size;
    i_req_addr[32*h +: 32] = addr;
    i_req_wdata[DW*h +: DW] = wdata;
  endtask

  task automatic wait_status(input int h);
    int n = 0;
    while (!(o_req_done[h] | o_req_error[h] | o_req_invalid[h]) && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL status_timeout host %0d: no status after %0d cycles, required within 300", h, n);
    end
  endtask

  task automatic clear_host(input int h);
    i_req_clear[h] = 1'b1;
    @(negedge i_clk);
    i_req_clear[h] = 1'b0;
  endtask

  task automatic release_host(input int h);
    i_req_rw[2*h +: 2] = 2'b00;
    clear_host(h);
  endtask

  // Behavioural master: answers each command with the next queued response.
  rsp_t m_r;
  initial begin
    i_m_wait = 0; i_m_done = 0; i_m_error = 0; i_m_invalid = 0; i_m_rdata = '0;
    forever begin
      @(negedge i_clk);
      if (i_rstn && o_m_rw != 2'b00) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL master_resp: command rw %b issued with no response queued", o_m_rw);
        end else begin
          m_r = rsp_q.pop_front();
          i_m_wait = 1'b1;
          for (int k = 0; k < m_r.lat; k++) begin
            @(negedge i_clk);
            if (!i_rstn) break;
          end
          if (i_rstn) begin
            i_m_wait = 1'b0;
            i_m_done = m_r.d; i_m_error = m_r.e; i_m_invalid = m_r.v; i_m_rdata = m_r.rdata;
            @(negedge i_clk);
            repeat (m_r.hold) @(negedge i_clk);
          end
          i_m_wait = 0; i_m_done = 0; i_m_error = 0; i_m_invalid = 0; i_m_rdata = '0;
        end
      end
    end
  end

  // Monitor: every issue and every clear pulse is matched against the scoreboard.
  iss_t mi;
  cmp_t mc;
  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rstn && o_m_rw != 2'b00) begin
        if (iss_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: grant %b rw %b, none expected", o_grant, o_m_rw);
        end else begin
          mi = iss_q.pop_front();
          chk("issue_grant", 64'(o_grant), 64'(1) << mi.h);
          chk("issue_wait", 64'(o_req_wait), 64'(1) << mi.h);
          chk("issue_rw", 64'(o_m_rw), 64'(mi.rw));
          chk("issue_size", 64'(o_m_size), 64'(mi.size));
          chk("issue_addr", 64'(o_m_addr), 64'(mi.addr));
          chk("issue_wdata", o_m_wdata, mi.wdata);
          chk("issue_state", 64'(o_state), 64'd1);
        end
      end
      if (i_rstn && o_m_clear) begin
        if (cmp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_clear: clear pulse with no completion expected");
        end else begin
          mc = cmp_q.pop_front();
          chk("cmpl_done", 64'(o_req_done[mc.h]), 64'(mc.d));
          chk("cmpl_error", 64'(o_req_error[mc.h]), 64'(mc.e));
          chk("cmpl_invalid", 64'(o_req_invalid[mc.h]), 64'(mc.v));
          chk("cmpl_rdata", o_req_rdata[DW*mc.h +: DW], mc.rdata);
          chk("cmpl_grant", 64'(o_grant), 64'd0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    i_req_rw = '0; i_req_size = '0; i_req_addr = '0; i_req_wdata = '0; i_req_clear = '0;
    repeat (2) @(negedge i_clk);
    chk("rst_state", 64'(o_state), 64'd0);
    chk("rst_grant", 64'(o_grant), 64'd0);
    chk("rst_m_rw", 64'(o_m_rw), 64'd0);
    chk("rst_m_clear", 64'(o_m_clear), 64'd0);
    chk("rst_status", 64'({o_req_done, o_req_error, o_req_invalid}), 64'd0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    @(negedge i_clk);

    // Single read from requester 0.
    expect_cmd(0, 2'b01, 3'd3, 32'h1000, 64'h0, 1, 0, 1, 0, 0, 64'hDEADBEEF_CAFEF00D);
    drive(0, 2'b01, 3'd3, 32'h1000, 64'h0);
    @(negedge i_clk);
    chk("issue_latency", 64'(o_req_wait[0]), 64'd1);
    wait_status(0);
    release_host(0);
    chk("clear_single_pulse", 64'(o_m_clear), 64'd0);
    chk("done0_cleared", 64'(o_req_done[0]), 64'd0);
    chk("rdata0_held", o_req_rdata[63:0], 64'hDEADBEEF_CAFEF00D);

    // Error to requester 1, then invalid (rw=11) to requester 2.
    expect_cmd(1, 2'b01, 3'd2, 32'h2004, 64'h0, 3, 0, 0, 1, 0, 64'h1111);
    drive(1, 2'b01, 3'd2, 32'h2004, 64'h0);
    wait_status(1);
    chk("err_only", 64'({o_req_done[1], o_req_error[1], o_req_invalid[1]}), 64'b010);
    release_host(1);
    expect_cmd(2, 2'b11, 3'd3, 32'h3000, 64'h55, 2, 0, 0, 0, 1, 64'h0);
    drive(2, 2'b11, 3'd3, 32'h3000, 64'h55);
    wait_status(2);
    chk("inv_only", 64'({o_req_done[2], o_req_error[2], o_req_invalid[2]}), 64'b001);
    release_host(2);

    // Pending status on requester 1 blocks its re-grant; requester 3 goes first.
    expect_cmd(1, 2'b01, 3'd3, 32'h4000, 64'h0, 2, 0, 1, 0, 0, 64'hA1);
    drive(1, 2'b01, 3'd3, 32'h4000, 64'h0);
    wait_status(1);
    expect_cmd(3, 2'b10, 3'd3, 32'h4100, 64'hB3, 2, 0, 1, 0, 0, 64'hB33);
    drive(3, 2'b10, 3'd3, 32'h4100, 64'hB3);
    wait_status(3);
    chk("done1_pending", 64'(o_req_done[1]), 64'd1);
    release_host(3);
    expect_cmd(1, 2'b01, 3'd3, 32'h4000, 64'h0, 2, 0, 1, 0, 0, 64'hA2);
    clear_host(1);
    wait_status(1);
    release_host(1);

    // Master status held after the clear pulse: no grant until it drops.
    expect_cmd(2, 2'b10, 3'd3, 32'h5000, 64'hC2, 1, 3, 1, 0, 0, 64'hC0);
    drive(2, 2'b10, 3'd3, 32'h5000, 64'hC2);
    wait_status(2);
    expect_cmd(3, 2'b01, 3'd3, 32'h5008, 64'h0, 1, 0, 1, 0, 0, 64'hD3);
    i_req_rw[5:4] = 2'b00;
    i_req_clear[2] = 1'b1;
    drive(3, 2'b01, 3'd3, 32'h5008, 64'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      i_req_clear[2] = 1'b0;
      chk("bp_nogrant", 64'(o_grant), 64'd0);
    end
    wait_status(3);
    release_host(3);

    // Round-robin: four simultaneous writes, requester 0 re-enters behind 3.
    for (int h = 0; h < N; h++)
      expect_cmd(h, 2'b10, 3'd3, 32'h6000 + 32'(h) * 32'h10, 64'h100 + 64'(h), 1, 0, 1, 0, 0, 64'h200 + 64'(h));
    expect_cmd(0, 2'b10, 3'd3, 32'h6000, 64'h100, 1, 0, 1, 0, 0, 64'h300);
    for (int h = 0; h < N; h++)
      drive(h, 2'b10, 3'd3, 32'h6000 + 32'(h) * 32'h10, 64'h100 + 64'(h));
    wait_status(0);
    clear_host(0);
    for (int h = 1; h < N; h++) begin
      wait_status(h);
      release_host(h);
    end
    wait_status(0);
    chk("rr_rdata0", o_req_rdata[63:0], 64'h300);
    release_host(0);

    // Asynchronous reset while BUSY, then priority restarts at requester 0.
    expect_cmd(1, 2'b01, 3'd3, 32'h7000, 64'h0, 10, 0, 1, 0, 0, 64'hEE);
    drive(1, 2'b01, 3'd3, 32'h7000, 64'h0);
    n = 0;
    while (o_state !== 2'd2 && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    chk("reach_busy", 64'(o_state), 64'd2);
    #2 i_rstn = 1'b0;
    #1;
    chk("arst_state", 64'(o_state), 64'd0);
    chk("arst_grant", 64'({o_grant, o_req_wait}), 64'd0);
    chk("arst_status", 64'({o_req_done, o_req_error, o_req_invalid}), 64'd0);
    chk("arst_rdata_zero", 64'(o_req_rdata != '0), 64'd0);
    chk("arst_master_cmd", 64'({o_m_rw, o_m_clear, o_m_size}), 64'd0);
    chk("arst_m_addr", 64'(o_m_addr), 64'd0);
    cmp_q.delete();
    i_req_rw = '0;
    repeat (3) @(negedge i_clk);
    i_rstn = 1'b1;
    @(negedge i_clk);
    expect_cmd(0, 2'b10, 3'd3, 32'h8000, 64'h80, 1, 0, 1, 0, 0, 64'h81);
    expect_cmd(2, 2'b01, 3'd3, 32'h8200, 64'h0, 1, 0, 1, 0, 0, 64'h82);
    drive(2, 2'b01, 3'd3, 32'h8200, 64'h0);
    drive(0, 2'b10, 3'd3, 32'h8000, 64'h80);
    wait_status(0);
    release_host(0);
    wait_status(2);
    release_host(2);

    repeat (5) @(negedge i_clk);
    chk("iss_q_drained", 64'(iss_q.size()), 64'd0);
    chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    chk("cmp_q_drained", 64'(cmp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
